// File: rtl/systolic_matmul_nxn.sv
// Output-stationary NxN systolic matrix multiplier: C = A*B with one inner-product
// index per beat, internal operand skew, and a valid/ready result handshake.

module systolic_skew_line #(
  parameter int W    = 16,
  parameter int SKEW = 0,
  parameter int TAPS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             d,
  output logic [TAPS-1:0][W-1:0]   q
);
  localparam int LEN = SKEW + TAPS;

  // sr[0] is the newest operand; the last TAPS stages feed the PEs along the line
  logic [LEN-1:0][W-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= '0;
    else      sr <= {sr[LEN-2:0], d};
  end

  assign q = sr[LEN-1:SKEW];
endmodule

module systolic_pe #(
  parameter int DW = 16,
  parameter int AW = 34
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          mode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc
);
  logic [AW-1:0] ea, eb, prod;

  assign ea   = mode ? {{(AW-DW){a[DW-1]}}, a} : {{(AW-DW){1'b0}}, a};
  assign eb   = mode ? {{(AW-DW){b[DW-1]}}, b} : {{(AW-DW){1'b0}}, b};
  assign prod = ea * eb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     acc <= '0;
    else if (clr) acc <= '0;
    else          acc <= acc + prod;
  end
endmodule

module systolic_matmul_nxn #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 2*DW + $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                signed_mode,
  input  logic [N*DW-1:0]     a_col,
  input  logic [N*DW-1:0]     b_row,
  output logic                c_valid,
  input  logic                c_ready,
  output logic [N*N*AW-1:0]   c_flat,
  output logic                busy
);
  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST_BEAT = CW'(N-1);
  localparam logic [CW-1:0] DRAIN_END = CW'(2*N-2);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           mode;
  logic           accept, clr;

  logic [N-1:0][DW-1:0]        a_lane, b_lane;
  logic [N-1:0][N-1:0][DW-1:0] a_tap, b_tap;

  assign accept = in_valid && in_ready;
  assign clr    = accept && (state == IDLE);

  // Non-accepting cycles push zeros, so stalls and drain add nothing to the sums
  assign a_lane = accept ? a_col : '0;
  assign b_lane = accept ? b_row : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mode     <= 1'b0;
      in_ready <= 1'b0;
      c_valid  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            mode <= signed_mode;
            busy <= 1'b1;
            if (N == 1) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
              cnt      <= '0;
            end else begin
              state <= FEED;
              cnt   <= CW'(1);
            end
          end
        end
        FEED: begin
          if (accept) begin
            if (cnt == LAST_BEAT) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_END) begin
            state   <= DONE;
            c_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (c_ready) begin
            state    <= IDLE;
            c_valid  <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row i of A and column j of B are delayed i and j stages before entering the grid
  for (genvar i = 0; i < N; i++) begin : g_skew
    systolic_skew_line #(.W(DW), .SKEW(i), .TAPS(N)) u_a_line (
      .clk(clk), .rst(rst), .d(a_lane[i]), .q(a_tap[i])
    );
    systolic_skew_line #(.W(DW), .SKEW(i), .TAPS(N)) u_b_line (
      .clk(clk), .rst(rst), .d(b_lane[i]), .q(b_tap[i])
    );
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .mode (mode),
        .a    (a_tap[i][j]),
        .b    (b_tap[j][i]),
        .acc  (c_flat[(i*N+j)*AW +: AW])
      );
    end
  end
endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Randomised and directed bench for systolic_matmul_nxn (N=4) against a plain
// inner-product reference model; smaller cases are embedded in the top-left corner.

module tb_systolic_matmul_nxn;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 2*DW + $clog2(N);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid, in_ready, signed_mode;
  logic [N*DW-1:0]    a_col, b_row;
  logic               c_valid, c_ready, busy;
  logic [N*N*AW-1:0]  c_flat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];

  systolic_matmul_nxn #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .signed_mode(signed_mode), .a_col(a_col), .b_row(b_row),
    .c_valid(c_valid), .c_ready(c_ready), .c_flat(c_flat), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] ref_c(int i, int j, bit sm);
    longint s = 0;
    longint x, y;
    for (int k = 0; k < N; k++) begin
      x = sm ? longint'($signed(ma[i][k])) : longint'(ma[i][k]);
      y = sm ? longint'($signed(mb[k][j])) : longint'(mb[k][j]);
      s += x * y;
    end
    return s[AW-1:0];
  endfunction

  function automatic logic [N*N*AW-1:0] ref_flat(bit sm);
    logic [N*N*AW-1:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[(i*N+j)*AW +: AW] = ref_c(i, j, sm);
    return r;
  endfunction

  function automatic logic [AW-1:0] got_c(int i, int j);
    return c_flat[(i*N+j)*AW +: AW];
  endfunction

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      a_col[i*DW +: DW] = DW'($urandom);
      b_row[i*DW +: DW] = DW'($urandom);
    end
    signed_mode = 1'($urandom);
  endtask

  task automatic zero_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = '0;
        mb[i][j] = '0;
      end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = DW'($urandom);
        mb[i][j] = DW'($urandom);
      end
  endtask

  task automatic case1_mats();
    zero_mats();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
  endtask

  // Presents N beats; gap1 extra stall cycles go between beat 0 and beat 1
  task automatic feed(input bit sm, input int stall_max, input int gap1, output int stalls);
    int t = 0;
    int s;
    stalls = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("start_rdy", 64'(in_ready), 64'd1);
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        s = int'($urandom_range(stall_max)) + ((k == 1) ? gap1 : 0);
        in_valid = 1'b0;
        repeat (s) begin
          rand_inputs();
          @(negedge clk);
        end
        stalls += s;
      end
      for (int i = 0; i < N; i++) begin
        a_col[i*DW +: DW] = ma[i][k];
        b_row[i*DW +: DW] = mb[k][i];
      end
      signed_mode = (k == 0) ? sm : 1'($urandom);
      in_valid = 1'b1;
      chk("beat_rdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      if (k == 0) t0 = cyc;
    end
    in_valid = 1'b0;
    rand_inputs();
  endtask

  task automatic finish(input bit sm, input int stalls, input int hold);
    int lat;
    logic [N*N*AW-1:0] ef;
    ef = ref_flat(sm);
    for (lat = 1; lat <= 40; lat++) begin
      @(posedge clk);
      #1;
      if (c_valid) break;
    end
    chk("lat_last", 64'(lat), 64'(2*N-1));
    chk("lat_total", 64'(cyc - t0), 64'(stalls + 3*N - 2));
    chk("done_rdy", 64'(in_ready), 64'd0);
    chk("done_busy", 64'(busy), 64'd1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("c[%0d][%0d]", i, j), 64'(got_c(i, j)), 64'(ef[(i*N+j)*AW +: AW]));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_vld", 64'(c_valid), 64'd1);
      chk("hold_rdy", 64'(in_ready), 64'd0);
      chk("hold_flat", 64'(c_flat === ef), 64'd1);
    end
    @(negedge clk);
    c_ready = 1'b1;
    @(posedge clk);
    #1;
    c_ready = 1'b0;
    chk("hs_vld", 64'(c_valid), 64'd0);
    chk("hs_rdy", 64'(in_ready), 64'd1);
    chk("hs_busy", 64'(busy), 64'd0);
    repeat (2) begin
      @(negedge clk);
      rand_inputs();
    end
    chk("idle_keep", 64'(c_flat === ef), 64'd1);
  endtask

  initial begin
    int st;
    bit sm;
    in_valid = 1'b0; c_ready = 1'b0; signed_mode = 1'b0;
    a_col = '0; b_row = '0;

    #2;
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_vld", 64'(c_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_flat", 64'(c_flat === '0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    chk("rdy_pre_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rdy_up", 64'(in_ready), 64'd1);

    case1_mats();
    feed(1'b0, 0, 0, st);
    finish(1'b0, st, 0);
    chk("t1_c00", 64'(got_c(0, 0)), 64'd19);
    chk("t1_c01", 64'(got_c(0, 1)), 64'd22);
    chk("t1_c10", 64'(got_c(1, 0)), 64'd43);
    chk("t1_c11", 64'(got_c(1, 1)), 64'd50);

    zero_mats();
    ma[0][0] = 16'hFFFF; ma[0][1] = 16'd2; ma[1][0] = 16'd3; ma[1][1] = 16'hFFFC;
    mb[0][0] = 16'd1;    mb[1][1] = 16'd1;
    feed(1'b1, 0, 0, st);
    finish(1'b1, st, 0);
    chk("sgn_c00", 64'(got_c(0, 0)), 64'h3_FFFF_FFFF);
    chk("sgn_c11", 64'(got_c(1, 1)), 64'h3_FFFF_FFFC);
    chk("sgn_c01", 64'(got_c(0, 1)), 64'd2);
    feed(1'b0, 0, 0, st);
    finish(1'b0, st, 0);
    chk("uns_c00", 64'(got_c(0, 0)), 64'hFFFF);
    chk("uns_c11", 64'(got_c(1, 1)), 64'hFFFC);

    case1_mats();
    feed(1'b0, 0, 3, st);
    finish(1'b0, st, 0);
    chk("stall_c11", 64'(got_c(1, 1)), 64'd50);

    case1_mats();
    feed(1'b0, 0, 0, st);
    finish(1'b0, st, 5);
    zero_mats();
    for (int i = 0; i < N; i++) ma[i][i] = 16'd1;
    mb[0][0] = 9; mb[0][1] = 8; mb[1][0] = 7; mb[1][1] = 6;
    feed(1'b0, 0, 0, st);
    finish(1'b0, st, 0);
    chk("b2b_c00", 64'(got_c(0, 0)), 64'd9);
    chk("b2b_c11", 64'(got_c(1, 1)), 64'd6);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 16'hFFFF;
        mb[i][j] = 16'hFFFF;
      end
    feed(1'b0, 0, 0, st);
    finish(1'b0, st, 0);
    chk("ones_c33", 64'(got_c(3, 3)), 64'd17179344900);
    chk("ones_c02", 64'(got_c(0, 2)), 64'd17179344900);

    // Abort a job during drain; the next job must carry no residue
    rand_mats();
    feed(1'b1, 0, 0, st);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rdy", 64'(in_ready), 64'd0);
    chk("abort_vld", 64'(c_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_flat", 64'(c_flat === '0), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    rand_mats();
    feed(1'b0, 1, 0, st);
    finish(1'b0, st, 1);

    for (int n = 0; n < 200; n++) begin
      rand_mats();
      sm = 1'($urandom);
      feed(sm, 2, 0, st);
      finish(sm, st, int'($urandom_range(3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/systolic_matmul_nxn.md
# systolic_matmul_nxn

Parametrised N×N output-stationary systolic matrix multiplier, the generalised successor to the fixed 2×2 array. It computes C = A·B for N×N matrices streamed in one inner-product index per beat. Operands are skewed internally, and the block accumulates in an N×N grid of MAC PEs. The full result is presented under a valid/ready handshake. It sits between the operand staging buffers and the result writeback path of the matrix engine.

## Interface
- N, 4: matrix dimension (≥2).
- DW, 16: operand element width.
- AW, 2*DW+$clog2(N): accumulator and result element width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat k presented.
- in_ready  out  1  block accepts a beat.
- signed_mode  in  1  1 = two's-complement operands; sampled on first beat of a job.
- a_col  in  N*DW  column k of A: lane i, bits [i*DW +: DW], = A[i][k].
- b_row  in  N*DW  row k of B: lane j = B[k][j].
- c_valid  out  1  result matrix valid.
- c_ready  in  1  consumer accepts result.
- c_flat  out  N*N*AW  C[i][j] at bits [(i*N+j)*AW +: AW].
- busy  out  1  high in FEED, DRAIN and DONE.

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE. A beat is accepted when in_valid && in_ready.
- IDLE: in_ready=1. The first accepted beat clears all accumulators and latches signed_mode. The beat counter is set to 1. Next state is FEED, or DRAIN if N beats are already complete (impossible for N≥2).
- FEED: in_ready=1 while beat count < N. Each accepted beat increments the counter. The Nth beat moves the FSM to DRAIN.
- Stall cycles in FEED (no beat accepted) inject zeros into every skew line. Zeros contribute nothing, so the result is unchanged.
- Skew: row i of A is delayed i stages and column j of B is delayed j stages. A operands shift right along rows; B operands shift down along columns.
- PE(i,j) adds A[i][k]*B[k][j] to its accumulator. The multiply is signed or unsigned per the latched mode; operands are extended to AW before accumulation.
- DRAIN: in_ready=0. A counter runs 2N-1 cycles, then the FSM moves to DONE.
- DONE: c_valid=1. c_flat holds the accumulator values, stable until the handshake. On c_valid && c_ready the FSM returns to IDLE.
- c_flat keeps the last result until the next job's first beat clears the accumulators.
- Arithmetic: with the default AW the result is exact. If AW is overridden smaller, results wrap modulo 2^AW with no saturation and no flag.

## Timing
- Reset values: in_ready=0, c_valid=0, busy=0, c_flat=0, FSM=IDLE. in_ready rises on the first clock edge after rst deasserts.
- Beat accepted at edge E_k: PE(i,j) accumulates that beat's product at edge E_k+i+j+1.
- Latency: c_valid rises at the (2N-1)th edge after the edge accepting the last beat. For N=4 with no stalls this is 10 edges from the first beat, i.e. 3 beats + 7.
- Stalls inside FEED delay c_valid by exactly the stall count.
- in_ready is 0 throughout DRAIN and DONE. A new job's first beat can be accepted at the earliest on the cycle after the c handshake (one IDLE cycle minimum).
- Reset asserted mid-operation (any state) immediately returns all outputs to their reset values. The partial job is discarded.
- in_valid held low in IDLE leaves all state unchanged.

## Test plan
- N=2, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], beats {a_col={1,3}, b_row={5,6}} then {a_col={2,4}, b_row={7,8}}, c_ready=1 -> C=[[19,22],[43,50]]. c_valid at the 3rd edge after beat 2; in_ready high again next cycle.
- N=2, signed_mode=1, A=[[-1,2],[3,-4]], B=I -> C=[[-1,2],[3,-4]] with correct AW sign extension. Rerun with signed_mode=0 on the same bits -> unsigned products.
- Stall: repeat the first case with in_valid low for 3 cycles between beats -> identical C; c_valid delayed exactly 3 cycles.
- Backpressure and back-to-back: hold c_ready low for 5 cycles -> c_valid and c_flat stable, in_ready=0. After the handshake, second job A=I, B=[[9,8],[7,6]] -> C=[[9,8],[7,6]], with the previous result fully cleared.
- N=4, DW=16, unsigned, all elements 65535 -> every C[i][j]=17179344900 (exact in AW=34). Also 200 random signed/unsigned jobs with random stalls and c_ready, checked against a reference model.
- Reset pulse low during DRAIN -> outputs at reset values within the same cycle. A fresh job afterwards produces the correct C with no residue from the aborted job.
